// File: rtl/ucsbece154b_branch_resolve_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_branch_resolve_pkg
// Description : Shared opcode constants and metadata sizing for the
//               branch-resolution slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ucsbece154b_branch_resolve_pkg;

    // RV32I control-transfer opcodes
    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    // Fixed part of a metadata word: valid + pred_taken + pred_target + pc
    localparam int c_META_FIXED_W = 1 + 1 + 32 + 32;

    // Full metadata word width for a given PHT index width
    function automatic int meta_width(input int ghr_bits);
        return c_META_FIXED_W + ghr_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ucsbece154b_pred_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_pred_pipe_reg
// Description : Width-parameterised pipeline register for prediction
//               metadata. Clear beats enable; a cleared word is all-zero,
//               which leaves the stage invalid and not predicted taken.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_pred_pipe_reg #(
    parameter int WIDTH = 71
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Stage register: reset/clear first, then hold unless enabled
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ucsbece154b_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : ucsbece154b_branch_resolve
// Description : Carries branch-prediction metadata from F through D to E,
//               checks it against the resolved outcome in E, and produces
//               the redirect plus BTB/PHT/GHR update strobes. Also keeps
//               saturating branch and mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [31:0]                        pcF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               StallE_i,
    input  logic                               FlushE_i,
    input  logic [6:0]                         opE_i,
    input  logic                               TakenE_i,
    input  logic [31:0]                        TargetE_i,
    input  logic [31:0]                        PCPlus4E_i,
    output logic                               MispredictE_o,
    output logic [31:0]                        PCredirectE_o,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic                               PHTincrement_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               GHRreset_o,
    output logic [31:0]                        branch_count_o,
    output logic [31:0]                        mispredict_count_o
);

    localparam int c_IDX_W   = $clog2(NUM_BTB_ENTRIES);
    localparam int c_META_W  = meta_width(NUM_GHR_BITS);
    // Field offsets inside a metadata word {valid, taken, target, pht, pc}
    localparam int c_PHT_LSB = 32;
    localparam int c_TGT_LSB = 32 + NUM_GHR_BITS;
    localparam int c_TKN_BIT = 64 + NUM_GHR_BITS;
    localparam int c_VLD_BIT = 65 + NUM_GHR_BITS;

    logic [c_META_W-1:0]     w_meta_f;
    logic [c_META_W-1:0]     r_meta_d;
    logic [c_META_W-1:0]     r_meta_e;
    logic                    w_valid_e;
    logic                    w_pred_taken_e;
    logic [31:0]             w_pred_target_e;
    logic [NUM_GHR_BITS-1:0] w_pht_addr_e;
    logic [31:0]             w_pc_e;
    logic                    w_is_br;
    logic                    w_is_j;
    logic                    w_actual_taken;
    logic                    w_mispredict;
    logic                    w_kill;
    logic [31:0]             r_branch_count;
    logic [31:0]             r_mispredict_count;

    assign w_meta_f = {1'b1, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i, pcF_i};

    // A mispredict is acted on once E is allowed to advance; while E is
    // stalled the same instruction keeps presenting its updates, and the
    // wrong-path kill happens on the release edge regardless of StallD_i.
    assign w_kill = w_mispredict & ~StallE_i;

    ucsbece154b_pred_pipe_reg #(.WIDTH(c_META_W)) u_meta_d (
        .clk (clk),
        .rst (reset_i),
        .en  (~StallD_i),
        .clr (FlushD_i | w_kill),
        .d   (w_meta_f),
        .q   (r_meta_d)
    );

    ucsbece154b_pred_pipe_reg #(.WIDTH(c_META_W)) u_meta_e (
        .clk (clk),
        .rst (reset_i),
        .en  (~StallE_i),
        .clr (FlushE_i | w_kill),
        .d   (r_meta_d),
        .q   (r_meta_e)
    );

    assign w_valid_e       = r_meta_e[c_VLD_BIT];
    assign w_pred_taken_e  = r_meta_e[c_TKN_BIT];
    assign w_pred_target_e = r_meta_e[c_TGT_LSB +: 32];
    assign w_pht_addr_e    = r_meta_e[c_PHT_LSB +: NUM_GHR_BITS];
    assign w_pc_e          = r_meta_e[31:0];

    // Resolve the E instruction and derive redirect/update strobes
    always_comb begin
        w_is_br        = (opE_i == instr_branch_op);
        w_is_j         = (opE_i == instr_jal_op) || (opE_i == instr_jalr_op);
        w_actual_taken = w_is_j | (w_is_br & TakenE_i);

        // A taken prediction on a non-control instruction (BTB alias) also
        // lands here because actual_taken is 0 for it.
        w_mispredict = w_valid_e &
                       ((w_pred_taken_e != w_actual_taken) |
                        (w_pred_taken_e & w_actual_taken & (w_pred_target_e != TargetE_i)));

        MispredictE_o = w_mispredict;
        PCredirectE_o = '0;
        if (w_mispredict) begin
            PCredirectE_o = w_actual_taken ? TargetE_i : PCPlus4E_i;
        end

        BTB_we_o          = w_valid_e & (w_is_br | w_is_j) & w_actual_taken &
                            (~w_pred_taken_e | (w_pred_target_e != TargetE_i));
        BTBwriteaddress_o = w_pc_e[c_IDX_W+1:2];
        BTBwritedata_o    = BTB_we_o ? TargetE_i : 32'd0;

        PHTwe_o           = w_valid_e & w_is_br;
        PHTincrement_o    = PHTwe_o & TakenE_i;
        PHTwriteaddress_o = w_pht_addr_e;

        GHRreset_o        = w_mispredict & w_is_br;
    end

    // Saturating event counters, advanced only when E is not stalled
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (!StallE_i) begin
            if (w_valid_e && (w_is_br || w_is_j) && (r_branch_count != 32'hFFFF_FFFF)) begin
                r_branch_count <= r_branch_count + 32'd1;
            end
            if (w_mispredict && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count_o     = r_branch_count;
    assign mispredict_count_o = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucsbece154b_branch_resolve
// Description : Directed bench with a cycle-level reference model of the
//               prediction pipeline and a per-cycle output comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_branch_resolve;

    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] pcF;
    logic        takenF;
    logic [31:0] tgtF;
    logic [4:0]  phtF;
    logic        stallD, flushD, stallE, flushE;
    logic [6:0]  opE;
    logic        takenE;
    logic [31:0] targetE, pc4E;
    logic        mp, btb_we, pht_we, pht_inc, ghr_rst;
    logic [31:0] redir, btb_data, bcount, mcount;
    logic [4:0]  btb_addr, pht_addr;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .pcF_i             (pcF),
        .BranchTakenF_i    (takenF),
        .BTBtargetF_i      (tgtF),
        .PHTreadaddressF_i (phtF),
        .StallD_i          (stallD),
        .FlushD_i          (flushD),
        .StallE_i          (stallE),
        .FlushE_i          (flushE),
        .opE_i             (opE),
        .TakenE_i          (takenE),
        .TargetE_i         (targetE),
        .PCPlus4E_i        (pc4E),
        .MispredictE_o     (mp),
        .PCredirectE_o     (redir),
        .BTB_we_o          (btb_we),
        .BTBwriteaddress_o (btb_addr),
        .BTBwritedata_o    (btb_data),
        .PHTwe_o           (pht_we),
        .PHTincrement_o    (pht_inc),
        .PHTwriteaddress_o (pht_addr),
        .GHRreset_o        (ghr_rst),
        .branch_count_o    (bcount),
        .mispredict_count_o(mcount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic        pt;
        logic [31:0] tgt;
        logic [4:0]  pht;
        logic [31:0] pc;
    } meta_t;

    meta_t       m_d = '0;
    meta_t       m_e = '0;
    logic [31:0] m_bc = '0;
    logic [31:0] m_mc = '0;

    function automatic logic is_ctl(input logic [6:0] op);
        return (op == OP_BEQ) || (op == OP_JAL) || (op == OP_JR);
    endfunction

    function automatic logic act_taken();
        return (opE == OP_JAL) || (opE == OP_JR) || ((opE == OP_BEQ) && takenE);
    endfunction

    function automatic logic exp_mp();
        logic at;
        at = act_taken();
        return m_e.v && ((m_e.pt != at) || (m_e.pt && at && (m_e.tgt != targetE)));
    endfunction

    function automatic logic exp_btb_we();
        return m_e.v && is_ctl(opE) && act_taken() && (!m_e.pt || (m_e.tgt != targetE));
    endfunction

    always @(posedge clk) begin
        meta_t old_d;
        logic  kill;
        if (reset_i) begin
            m_d  = '0;
            m_e  = '0;
            m_bc = '0;
            m_mc = '0;
        end else begin
            kill  = exp_mp() && !stallE;
            if (!stallE) begin
                if (m_e.v && is_ctl(opE) && (m_bc != 32'hFFFF_FFFF)) m_bc = m_bc + 1;
                if (exp_mp() && (m_mc != 32'hFFFF_FFFF)) m_mc = m_mc + 1;
            end
            old_d = m_d;
            if (flushE || kill) m_e = '0;
            else if (!stallE)   m_e = old_d;
            if (flushD || kill) m_d = '0;
            else if (!stallD)   m_d = '{v: 1'b1, pt: takenF, tgt: tgtF, pht: phtF, pc: pcF};
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        logic e_mp, e_btb, e_pht;
        if (cmp_en) begin
            e_mp  = exp_mp();
            e_btb = exp_btb_we();
            e_pht = m_e.v && (opE == OP_BEQ);
            chk("mispredict", {31'd0, mp}, {31'd0, e_mp});
            chk("redirect", redir, e_mp ? (act_taken() ? targetE : pc4E) : 32'd0);
            chk("btb_we", {31'd0, btb_we}, {31'd0, e_btb});
            chk("pht_we", {31'd0, pht_we}, {31'd0, e_pht});
            chk("ghr_reset", {31'd0, ghr_rst}, {31'd0, e_mp && (opE == OP_BEQ)});
            chk("branch_count", bcount, m_bc);
            chk("mispredict_count", mcount, m_mc);
            if (e_btb) begin
                chk("btb_addr", {27'd0, btb_addr}, {27'd0, m_e.pc[6:2]});
                chk("btb_data", btb_data, targetE);
            end
            if (e_pht) begin
                chk("pht_inc", {31'd0, pht_inc}, {31'd0, takenE});
                chk("pht_addr", {27'd0, pht_addr}, {27'd0, m_e.pht});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
        pcF = pc; takenF = pt; tgtF = tgt; phtF = pht;
    endtask

    task automatic set_e(input logic [6:0] op, input logic tk, input logic [31:0] tgt, input logic [31:0] pc4);
        opE = op; takenE = tk; targetE = tgt; pc4E = pc4;
    endtask

    task automatic e_idle();
        set_e(OP_ADD, 1'b0, 32'd0, 32'd0);
    endtask

    // Fetch one instruction and advance it into E
    task automatic issue(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic [4:0] pht);
        set_f(pc, pt, tgt, pht);
        step();
        set_f(32'h1000, 1'b0, 32'd0, 5'd0);
        step();
    endtask

    initial begin
        reset_i = 1'b1;
        stallD = 0; flushD = 0; stallE = 0; flushE = 0;
        set_f(32'h1000, 1'b0, 32'd0, 5'd0);
        e_idle();
        step();
        cmp_en = 1'b1;
        step();
        chk("rst_mispredict", {31'd0, mp}, 32'd0);
        chk("rst_redirect", redir, 32'd0);
        chk("rst_btb_we", {31'd0, btb_we}, 32'd0);
        chk("rst_pht_we", {31'd0, pht_we}, 32'd0);
        chk("rst_counts", bcount | mcount, 32'd0);
        reset_i = 1'b0;

        // beq predicted not-taken, actually taken
        issue(32'h100, 1'b0, 32'd0, 5'd3);
        set_e(OP_BEQ, 1'b1, 32'h140, 32'h104);
        #1;
        chk("t1_mp", {31'd0, mp}, 32'd1);
        chk("t1_redirect", redir, 32'h140);
        chk("t1_btb_we", {31'd0, btb_we}, 32'd1);
        chk("t1_btb_addr", {27'd0, btb_addr}, 32'd0);
        chk("t1_btb_data", btb_data, 32'h140);
        chk("t1_pht", {29'd0, pht_we, pht_inc, ghr_rst}, 32'd7);
        step();
        chk("t1_killed_mp", {31'd0, mp}, 32'd0);
        chk("t1_killed_pht", {31'd0, pht_we}, 32'd0);
        chk("t1_counts", {bcount[15:0], mcount[15:0]}, 32'h0001_0001);
        e_idle();

        // beq correctly predicted taken
        issue(32'h100, 1'b1, 32'h140, 5'd4);
        set_e(OP_BEQ, 1'b1, 32'h140, 32'h104);
        #1;
        chk("t2_mp", {31'd0, mp}, 32'd0);
        chk("t2_btb_we", {31'd0, btb_we}, 32'd0);
        chk("t2_pht", {30'd0, pht_we, pht_inc}, 32'd3);
        chk("t2_pht_addr", {27'd0, pht_addr}, 32'd4);
        step();
        e_idle();
        chk("t2_counts", {bcount[15:0], mcount[15:0]}, 32'h0002_0001);

        // add aliased to a taken BTB entry
        issue(32'h200, 1'b1, 32'h300, 5'd0);
        set_e(OP_ADD, 1'b1, 32'h300, 32'h204);
        #1;
        chk("t3_mp", {31'd0, mp}, 32'd1);
        chk("t3_redirect", redir, 32'h204);
        chk("t3_upd", {29'd0, pht_we, btb_we, ghr_rst}, 32'd0);
        step();
        e_idle();
        chk("t3_counts", {bcount[15:0], mcount[15:0]}, 32'h0002_0002);

        // jal with wrong predicted target
        issue(32'h40, 1'b1, 32'h80, 5'd0);
        set_e(OP_JAL, 1'b0, 32'h90, 32'h44);
        #1;
        chk("t4_mp", {31'd0, mp}, 32'd1);
        chk("t4_redirect", redir, 32'h90);
        chk("t4_btb", {27'd0, btb_we, btb_addr[3:0]}, {27'd0, 1'b1, 4'h0});
        chk("t4_btb_addr", {27'd0, btb_addr}, 32'd16);
        chk("t4_btb_data", btb_data, 32'h90);
        chk("t4_pht_ghr", {30'd0, pht_we, ghr_rst}, 32'd0);
        step();
        e_idle();
        chk("t4_counts", {bcount[15:0], mcount[15:0]}, 32'h0003_0003);

        // mispredicting beq held in E by StallE for three cycles
        issue(32'h104, 1'b0, 32'd0, 5'd7);
        set_e(OP_BEQ, 1'b1, 32'h180, 32'h108);
        stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_mp", {31'd0, mp}, 32'd1);
            chk("t5_stall_redirect", redir, 32'h180);
            chk("t5_stall_mcount", mcount, 32'd3);
            step();
        end
        stallE = 1'b0;
        #1;
        chk("t5_release_mp", {31'd0, mp}, 32'd1);
        step();
        e_idle();
        chk("t5_counts", {bcount[15:0], mcount[15:0]}, 32'h0004_0004);

        // FlushD together with StallD leaves D invalid
        set_f(32'h500, 1'b1, 32'h600, 5'd0);
        step();
        set_f(32'h1000, 1'b0, 32'd0, 5'd0);
        stallD = 1'b1; flushD = 1'b1;
        step();
        stallD = 1'b0; flushD = 1'b0;
        step();
        set_e(OP_ADD, 1'b0, 32'd0, 32'h504);
        #1;
        chk("t5_flushd_mp", {31'd0, mp}, 32'd0);
        e_idle();

        // mispredict counter saturation
        dut.r_mispredict_count = 32'hFFFF_FFFF;
        m_mc = 32'hFFFF_FFFF;
        issue(32'h200, 1'b1, 32'h300, 5'd0);
        set_e(OP_ADD, 1'b0, 32'd0, 32'h204);
        #1;
        chk("t6_mp", {31'd0, mp}, 32'd1);
        step();
        e_idle();
        chk("t6_saturated", mcount, 32'hFFFF_FFFF);

        // reset in the middle of a mispredicting beq
        issue(32'h100, 1'b0, 32'd0, 5'd2);
        set_e(OP_BEQ, 1'b1, 32'h140, 32'h104);
        reset_i = 1'b1;
        #1;
        chk("t7_pre_mp", {31'd0, mp}, 32'd1);
        step();
        chk("t7_mp", {31'd0, mp}, 32'd0);
        chk("t7_redirect", redir, 32'd0);
        chk("t7_upd", {29'd0, btb_we, pht_we, ghr_rst}, 32'd0);
        chk("t7_counts", bcount | mcount, 32'd0);
        reset_i = 1'b0;
        step();
        chk("t7_idle_mp", {31'd0, mp}, 32'd0);
        e_idle();
        repeat (3) step();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_branch_resolve.md
Name: ucsbece154b_branch_resolve

Overview:
Execute-stage consumer of the fetch-stage branch predictor's outputs. Carries each fetched instruction's prediction metadata (taken bit, predicted target, PHT index) through D and E. Compares the prediction against the actual outcome resolved in E, raises mispredict plus redirect PC, and drives the predictor's BTB/PHT/GHR update ports. Also keeps saturating branch and mispredict counters.

Parameters:
NUM_BTB_ENTRIES, 32, BTB depth; write index = pc[$clog2(NUM_BTB_ENTRIES)+1:2]
NUM_GHR_BITS, 5, PHT index width, matches predictor

Ports:
clk  in  1  clock
reset_i  in  1  synchronous active-high reset
pcF_i  in  32  fetch PC
BranchTakenF_i  in  1  predictor taken prediction for pcF_i
BTBtargetF_i  in  32  predictor target for pcF_i
PHTreadaddressF_i  in  NUM_GHR_BITS  PHT index used for pcF_i
StallD_i  in  1  hold F->D metadata register
FlushD_i  in  1  clear D metadata
StallE_i  in  1  hold D->E metadata register
FlushE_i  in  1  clear E metadata
opE_i  in  7  opcode of instruction in E
TakenE_i  in  1  actual branch condition (ignored unless opE_i is a branch)
TargetE_i  in  32  actual computed target in E
PCPlus4E_i  in  32  fall-through PC of E instruction
MispredictE_o  out  1  E instruction mispredicted
PCredirectE_o  out  32  correct next PC when MispredictE_o=1
BTB_we_o  out  1  BTB write enable
BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  BTB write index
BTBwritedata_o  out  32  BTB target
PHTwe_o  out  1  PHT write enable
PHTincrement_o  out  1  1=taken, 0=not taken
PHTwriteaddress_o  out  NUM_GHR_BITS  PHT index from E metadata
GHRreset_o  out  1  clear GHR after conditional-branch mispredict
branch_count_o  out  32  resolved control instructions
mispredict_count_o  out  32  mispredicts

Behaviour:
- Metadata per stage: {valid, pred_taken, pred_target[31:0], pht_addr, pc[31:0]}. D captures F inputs with valid=1. E captures D.
- Per stage, per cycle: flush (FlushX_i or internal mispredict clear) wins over stall, then stall holds, else load. Flush sets valid=0 and pred_taken=0.
- Reset: both stages invalid. Counters 0. All outputs 0, including PCredirectE_o=0.
- E decode: is_br = opE_i==instr_branch_op; is_j = jal or jalr op. actual_taken = is_j | (is_br & TakenE_i).
- Mispredict (combinational from E regs and E inputs): validE & (pred_taken != actual_taken, or pred_taken & actual_taken & pred_target != TargetE_i).
  - A non-control instruction predicted taken (BTB alias) is a mispredict.
- PCredirectE_o = actual_taken ? TargetE_i : PCPlus4E_i while mispredicting, else 0.
- BTB_we_o = validE & (is_br|is_j) & actual_taken & (!pred_taken | pred_target != TargetE_i). BTBwriteaddress_o = pcE index bits. BTBwritedata_o = TargetE_i.
- PHTwe_o = validE & is_br. PHTincrement_o = TakenE_i. PHTwriteaddress_o = pht_addrE.
- GHRreset_o = MispredictE_o & is_br.
- All update/redirect outputs are combinational, same cycle as E. Predictor commits them at the next clk edge. Zero added latency.
- Mispredict: at the next edge, D and E metadata clear regardless of stalls, killing wrong-path predictions.
- StallE_i=1 with a valid E: outputs still assert every stalled cycle. Counters increment only on non-stalled cycles.
- Counters: branch_count += validE & (is_br|is_j) & !StallE_i. mispredict_count += MispredictE_o & !StallE_i. Both saturate at 32'hFFFF_FFFF, no wrap.
- Reset mid-operation: next cycle fully idle. No update from a pre-reset E instruction.

Decomposition:
- Opcode constants (instr_branch_op, instr_jal_op, instr_jalr_op) come from the shared ucsbece154b_defines.vh.
- Add a metadata-width localparam there (1+1+32+NUM_GHR_BITS+32).
- One sub-module: ucsbece154b_pred_pipe_reg (width-parameterised register with en/clr, flush priority), instantiated for D and E.
- Compare/update logic and counters stay in the top.

Test Plan:
- Beq at pc 0x100, predicted not-taken, TakenE_i=1, TargetE_i=0x140 -> MispredictE_o=1, PCredirectE_o=0x140, BTB_we_o=1, index 0, data 0x140, PHTwe_o=1, PHTincrement_o=1, GHRreset_o=1. Next cycle D/E invalid.
- Beq predicted taken to 0x140, actual taken to 0x140 -> MispredictE_o=0, BTB_we_o=0, PHTwe_o=1, inc=1. branch_count +1, mispredict_count unchanged.
- Add (opcode 0110011) at 0x200 with BranchTakenF_i=1, target 0x300 -> MispredictE_o=1, PCredirectE_o=PCPlus4E_i=0x204, PHTwe_o=0, BTB_we_o=0, GHRreset_o=0.
- Jal predicted taken to 0x80, actual TargetE_i=0x90 -> mispredict, redirect 0x90, BTB_we_o=1, data 0x90, PHTwe_o=0.
- StallE_i=1 for 3 cycles on a mispredicting beq -> outputs held all 3 cycles. mispredict_count +1 only after release. FlushD_i with StallD_i simultaneously -> D invalid.
- Force mispredict_count to 0xFFFFFFFF, mispredict again -> stays 0xFFFFFFFF. Assert reset_i mid-stream -> all outputs 0 next cycle, counters 0.
